s8_avmm_responder: RTL and testbench
====================================

// Module: s8_avmm_responder
// PURPOSE
// - AVMM slave (responder) terminating the sector-8 PR user-logic AVMM master: 32-bit register target on the NoC.
// - Accepts single-word reads/writes, returns read data over a fixed-latency pipeline (readdatavalid).
// - Holds ID/control/error registers and a scratch register file.
// - Post-reset and soft-reset init sequence clears the scratch file.
// PARAMETERS
// - ADDR_W        20           AVMM byte-address width
// - NUM_REGS      16           scratch registers at 0x00100+4*i (power of 2, 2..64)
// - READ_LATENCY  2            accept-to-readdatavalid cycles (1..4)
// - ID_VALUE      32'h5EC7_0008  value of ID register
// PORTS
// - clk                        in   1       clock
// - rst                        in   1       synchronous active-low reset
// - avmm_slave_address         in   ADDR_W  byte address; [1:0] ignored
// - avmm_slave_read            in   1       read command
// - avmm_slave_write           in   1       write command
// - avmm_slave_writedata       in   32      write data
// - avmm_slave_waitrequest     out  1       command stall; master holds command while high
// - avmm_slave_readdata        out  32      read response data
// - avmm_slave_readdatavalid   out  1       readdata qualifier, 1 cycle per accepted read
// - ready                      out  1       high in READY state
// BEHAVIOUR
// - Reset (rst==0 at posedge): waitrequest=1, readdatavalid=0, readdata=0, ready=0, pipeline flushed, ERR=0, CTRL=0; FSM->INIT, init_idx=0.
// - FSM INIT: waitrequest=1; scratch[init_idx]<=0, init_idx++ per cycle; after NUM_REGS cycles ->READY.
// - FSM READY: waitrequest=0 combinationally, ready=1. Accept = (read|write) & ~waitrequest.
// - Map (addr[ADDR_W-1:2]): 0x000 ID RO; 0x004 CTRL RW [0]=soft_init self-clearing, [31:1] RW scratch; 0x008 ERR RO error count (saturates at 0xFFFF_FFFF); 0x100+4i scratch i.
// - Write: takes effect at accept edge; read accepted next cycle returns new value.
// - Write CTRL[0]=1: CTRL[0] reads 0; FSM->INIT next cycle (waitrequest=1 from cycle after accept).
// - Read: data sampled at accept cycle; readdatavalid exactly READ_LATENCY cycles after accept; back-to-back reads give back-to-back responses, order preserved; no response backpressure.
// - Reads in flight at soft init complete normally with pre-init data.
// - Unmapped read -> 32'hDEAD_BEEF, ERR++. Unmapped or RO write -> dropped, ERR++.
// - read & write both high -> write performed, read dropped (no readdatavalid), ERR++.
// - Simultaneous ERR increments in one cycle count once.
// - Reset mid-operation: pipeline cleared, pending responses never issued.
// CONFIGURATION
// - S8_RESP_PERF_CNT_EN defined:
//   - 0x010 RD_CNT RO, 0x014 WR_CNT RO: 32-bit wrapping counts of accepted reads/writes.
//   - Both cleared by reset and soft init.
// - Undefined: 0x010/0x014 unmapped (read DEAD_BEEF, ERR++); no counter flops.
// STRUCTURE
// - s8_noc_pkg: register offset localparams, DEAD_BEEF constant, typedef enum logic {INIT, READY} resp_state_t.
// - Sub-module s8_rd_pipe: READY_LATENCY-deep valid/data shift register with synchronous clear.
// TESTING
// - Reset release:
//   - waitrequest=1 for 16 cycles, then 0 and ready=1.
//   - Read 0x00000 -> readdatavalid 2 cycles later, data 0x5EC70008.
// - Write 0x00104=0xA5A5_0001, next-cycle read 0x00104 -> 0xA5A50001; read 0x00108 -> 0.
// - 8 back-to-back reads 0x00100..0x0011C -> 8 consecutive readdatavalid cycles, in address order.
// - Errors:
//   - Write 0x00000, read 0x7FFFC, read&write together -> ERR=3.
//   - Read 0x7FFFC returns 0xDEADBEEF.
// - Soft init: read scratch, then write CTRL=1 on the next cycle.
//   - Pending read returns old data.
//   - waitrequest high 16 cycles; scratch then reads 0.
// - Perf counters:
//   - With S8_RESP_PERF_CNT_EN: 3 writes + 2 reads -> RD_CNT reads 2 (read of RD_CNT not yet counted), WR_CNT=3.
//   - Without: 0x010 -> DEADBEEF.

Source files
------------

// File: rtl/s8_noc_pkg.sv
// Shared definitions for the sector-8 AVMM register responder: register map,
// fill value for unmapped reads and the responder FSM state type.
package s8_noc_pkg;

    localparam int unsigned REG_ID_OFF       = 32'h000;
    localparam int unsigned REG_CTRL_OFF     = 32'h004;
    localparam int unsigned REG_ERR_OFF      = 32'h008;
    localparam int unsigned REG_RD_CNT_OFF   = 32'h010;
    localparam int unsigned REG_WR_CNT_OFF   = 32'h014;
    localparam int unsigned SCRATCH_BASE_OFF = 32'h100;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic {
        INIT,
        READY
    } resp_state_t;

    // Byte offset to 32-bit word index.
    function automatic int unsigned word_off(input int unsigned byte_off);
        return byte_off >> 2;
    endfunction

endpackage

// File: rtl/s8_avmm_responder_if.sv
// AVMM slave-side bus bundle between the PR user-logic master and the
// register responder.
interface s8_avmm_responder_if #(
    parameter int unsigned ADDR_W = 20
);
    logic [ADDR_W-1:0] avmm_slave_address;
    logic              avmm_slave_read;
    logic              avmm_slave_write;
    logic [31:0]       avmm_slave_writedata;
    logic              avmm_slave_waitrequest;
    logic [31:0]       avmm_slave_readdata;
    logic              avmm_slave_readdatavalid;

    modport master (
        output avmm_slave_address,
        output avmm_slave_read,
        output avmm_slave_write,
        output avmm_slave_writedata,
        input  avmm_slave_waitrequest,
        input  avmm_slave_readdata,
        input  avmm_slave_readdatavalid
    );

    modport slave (
        input  avmm_slave_address,
        input  avmm_slave_read,
        input  avmm_slave_write,
        input  avmm_slave_writedata,
        output avmm_slave_waitrequest,
        output avmm_slave_readdata,
        output avmm_slave_readdatavalid
    );
endinterface

// File: rtl/s8_rd_pipe.sv
// Fixed-latency read response pipeline: LATENCY-deep valid/data shift register,
// flushed by the synchronous active-low reset.
module s8_rd_pipe #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data
);

    logic              valid_q [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            data_q[0]  <= push_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign pop_valid = valid_q[LATENCY-1];
    assign pop_data  = data_q[LATENCY-1];

endmodule

// File: rtl/s8_avmm_responder.sv
// AVMM register responder for the sector-8 PR master: ID/CTRL/ERR, scratch file,
// fixed-latency reads. Optional RD_CNT/WR_CNT via macro S8_RESP_PERF_CNT_EN.
module s8_avmm_responder
    import s8_noc_pkg::*;
#(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] ID_VALUE     = 32'h5EC7_0008
) (
    input  logic               clk,
    input  logic               rst,
    s8_avmm_responder_if.slave avmm,
    output logic               ready
);

    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);

    localparam logic [WORD_W-1:0] W_ID     = WORD_W'(word_off(REG_ID_OFF));
    localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(word_off(REG_CTRL_OFF));
    localparam logic [WORD_W-1:0] W_ERR    = WORD_W'(word_off(REG_ERR_OFF));
    localparam logic [WORD_W-1:0] W_SCR_LO = WORD_W'(word_off(SCRATCH_BASE_OFF));
    localparam logic [WORD_W-1:0] W_SCR_HI = WORD_W'(word_off(SCRATCH_BASE_OFF) + NUM_REGS - 1);

    resp_state_t       state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic [31:0]       scratch_q [NUM_REGS];
    logic [31:1]       ctrl_q;
    logic [31:0]       err_q;

    logic [WORD_W-1:0] waddr;
    logic [IDX_W-1:0]  sidx;
    logic              unused_addr_lsb;
    logic              waitrequest;
    logic              rd_req, wr_req, rd_acc;
    logic              hit_id, hit_ctrl, hit_err, hit_scr;
    logic              rd_mapped, wr_mapped;
    logic              err_inc, soft_init;
    logic [31:0]       rd_data;
    logic [31:0]       wdata;

    assign waddr           = avmm.avmm_slave_address[ADDR_W-1:2];
    assign unused_addr_lsb = ^avmm.avmm_slave_address[1:0];
    // Scratch base is 64-word aligned, so the low word-address bits index the file.
    assign sidx            = waddr[IDX_W-1:0];
    assign wdata           = avmm.avmm_slave_writedata;

    assign waitrequest                 = (state_q != READY);
    assign avmm.avmm_slave_waitrequest = waitrequest;
    assign ready                       = (state_q == READY);

    assign rd_req = avmm.avmm_slave_read & ~waitrequest;
    assign wr_req = avmm.avmm_slave_write & ~waitrequest;
    // A combined read+write performs only the write.
    assign rd_acc = rd_req & ~wr_req;

    assign hit_id    = (waddr == W_ID);
    assign hit_ctrl  = (waddr == W_CTRL);
    assign hit_err   = (waddr == W_ERR);
    assign hit_scr   = (waddr >= W_SCR_LO) && (waddr <= W_SCR_HI);
    assign wr_mapped = hit_ctrl | hit_scr;

    assign soft_init = wr_req & hit_ctrl & wdata[0];

`ifdef S8_RESP_PERF_CNT_EN
    localparam logic [WORD_W-1:0] W_RD_CNT = WORD_W'(word_off(REG_RD_CNT_OFF));
    localparam logic [WORD_W-1:0] W_WR_CNT = WORD_W'(word_off(REG_WR_CNT_OFF));

    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || soft_init) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_req) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_data   = DEAD_BEEF;
        rd_mapped = 1'b1;
        if (hit_id) begin
            rd_data = ID_VALUE;
        end else if (hit_ctrl) begin
            rd_data = {ctrl_q, 1'b0};
        end else if (hit_err) begin
            rd_data = err_q;
        end else if (hit_scr) begin
            rd_data = scratch_q[sidx];
`ifdef S8_RESP_PERF_CNT_EN
        end else if (waddr == W_RD_CNT) begin
            rd_data = rd_cnt_q;
        end else if (waddr == W_WR_CNT) begin
            rd_data = wr_cnt_q;
`endif
        end else begin
            rd_mapped = 1'b0;
        end
    end

    // All error sources in one cycle collapse to a single increment.
    assign err_inc = (rd_acc & ~rd_mapped) | (wr_req & ~wr_mapped) | (rd_req & wr_req);

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d    = READY;
                    init_idx_d = '0;
                end
            end
            READY: begin
                if (soft_init) begin
                    state_d    = INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                init_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // No reset on the file itself: INIT always follows reset and clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            scratch_q[init_idx_q] <= '0;
        end else if (wr_req && hit_scr) begin
            scratch_q[sidx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= '0;
            err_q  <= '0;
        end else begin
            if (wr_req && hit_ctrl) ctrl_q <= wdata[31:1];
            if (err_inc && (err_q != '1)) err_q <= err_q + 32'd1;
        end
    end

    s8_rd_pipe #(
        .LATENCY(READ_LATENCY),
        .DATA_W (32)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .push_valid(rd_acc),
        .push_data (rd_acc ? rd_data : 32'd0),
        .pop_valid (avmm.avmm_slave_readdatavalid),
        .pop_data  (avmm.avmm_slave_readdata)
    );

endmodule

// File: tb/tb_s8_avmm_responder.sv
// Directed bench for s8_avmm_responder: reset/init, map, latency, errors,
// soft init, optional perf counters (S8_RESP_PERF_CNT_EN) and mid-run reset.
module tb_s8_avmm_responder;

    logic clk = 1'b0;
    logic rst;
    logic ready;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic [31:0] exp_b2b [8];

    always #5 clk = ~clk;

    s8_avmm_responder_if #(.ADDR_W(20)) bus_if ();

    s8_avmm_responder #(
        .ADDR_W      (20),
        .NUM_REGS    (16),
        .READ_LATENCY(2),
        .ID_VALUE    (32'h5EC7_0008)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .avmm (bus_if.slave),
        .ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [19:0] a,
                         input logic [31:0] d);
        bus_if.avmm_slave_read      = rd;
        bus_if.avmm_slave_write     = wr;
        bus_if.avmm_slave_address   = a;
        bus_if.avmm_slave_writedata = d;
    endtask

    // Called at posedge+1; holds the command for one cycle.
    task automatic bus(input logic rd, input logic wr, input logic [19:0] a,
                       input logic [31:0] d);
        drive(rd, wr, a, d);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 20'h0, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [19:0] a, input logic [31:0] exp);
        bus(1'b1, 1'b0, a, 32'h0);
        @(negedge clk);
        chk({tag, "_early_rdv"}, 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_rdv"}, 32'(bus_if.avmm_slave_readdatavalid), 32'd1);
        chk({tag, "_data"}, bus_if.avmm_slave_readdata, exp);
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge; counts cycles with waitrequest high (bounded).
    task automatic count_wait(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.avmm_slave_waitrequest !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 20'h0, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waitreq", 32'(bus_if.avmm_slave_waitrequest), 32'd1);
        chk("rst_rdv", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        chk("rst_rdata", bus_if.avmm_slave_readdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        count_wait(n);
        chk("init_wait_cycles", 32'(n), 32'd16);
        chk("init_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;

        do_read("id", 20'h00000, 32'h5EC7_0008);
        bus(1'b0, 1'b1, 20'h00104, 32'hA5A5_0001);
        do_read("scr1_wr_rd", 20'h00104, 32'hA5A5_0001);
        do_read("scr2_zero", 20'h00108, 32'h0);
        bus(1'b0, 1'b1, 20'h00004, 32'hFFFF_FFF0);
        do_read("ctrl_rw", 20'h00004, 32'hFFFF_FFF0);

        for (int i = 0; i < 8; i++) begin
            exp_b2b[i] = 32'h1000_0000 + 32'(i) * 32'h11;
            bus(1'b0, 1'b1, 20'h00100 + 20'(4 * i), exp_b2b[i]);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 20'h00100 + 20'(4 * i), 32'h0);
            else drive(1'b0, 1'b0, 20'h0, 32'h0);
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("b2b%0d_rdv", i - 2), 32'(bus_if.avmm_slave_readdatavalid), 32'd1);
                chk($sformatf("b2b%0d_data", i - 2), bus_if.avmm_slave_readdata, exp_b2b[i-2]);
            end else begin
                chk($sformatf("b2b_lead%0d_rdv", i), 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 20'h0, 32'h0);
        @(negedge clk);
        chk("b2b_tail_rdv", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        @(posedge clk);
        #1;

        bus(1'b0, 1'b1, 20'h00000, 32'h1234_5678);
        do_read("unmapped", 20'h7FFFC, 32'hDEAD_BEEF);
        bus(1'b1, 1'b1, 20'h0011C, 32'hCAFE_F00D);
        @(negedge clk);
        chk("rw_rdv1", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rw_rdv2", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        do_read("err_cnt", 20'h00008, 32'd3);
        do_read("rw_write_done", 20'h0011C, 32'hCAFE_F00D);
        do_read("id_ro", 20'h00000, 32'h5EC7_0008);

        bus(1'b1, 1'b0, 20'h00100, 32'h0);
        bus(1'b0, 1'b1, 20'h00004, 32'h0000_0001);
        @(negedge clk);
        chk("soft_pend_rdv", 32'(bus_if.avmm_slave_readdatavalid), 32'd1);
        chk("soft_pend_data", bus_if.avmm_slave_readdata, 32'h1000_0000);
        count_wait(n);
        chk("soft_wait_cycles", 32'(n), 32'd16);
        @(posedge clk);
        #1;

        do_read("soft_scr0", 20'h00100, 32'h0);
        do_read("soft_scr7", 20'h0011C, 32'h0);
`ifdef S8_RESP_PERF_CNT_EN
        bus(1'b0, 1'b1, 20'h00104, 32'h1);
        bus(1'b0, 1'b1, 20'h00108, 32'h2);
        bus(1'b0, 1'b1, 20'h0010C, 32'h3);
        do_read("rd_cnt", 20'h00010, 32'd2);
        do_read("wr_cnt", 20'h00014, 32'd3);
`else
        do_read("perf_unmapped", 20'h00010, 32'hDEAD_BEEF);
`endif
        do_read("ctrl_selfclr", 20'h00004, 32'h0);

        bus(1'b1, 1'b0, 20'h00000, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rdv1", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_rdv2", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);
        chk("midrst_rdata", bus_if.avmm_slave_readdata, 32'h0);
        chk("midrst_waitreq", 32'(bus_if.avmm_slave_waitrequest), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_rdv3", 32'(bus_if.avmm_slave_readdatavalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
